// File: rtl/ddr2_read_engine.sv
// ---------------------------------------------------------------------------
// ddr2_read_engine
//
// Issues a run of burst_len read commands on the MIG user interface, starting
// at start_addr and stepping by ADDR_STEP per accepted command. The number of
// accepted-but-unreturned commands is capped at MAX_OUTSTANDING. Returned
// beats are counted and forwarded one cycle later on rd_data/rd_valid.
//
// Ports:
//   clk_in             MIG ui_clk
//   rst_n              asynchronous active-low reset
//   start              one-cycle run request, honoured only in IDLE
//   start_addr         first command address, latched on start
//   burst_len          number of read commands, latched on start
//   busy               run in progress
//   done               one-cycle pulse once every beat has returned
//   err                sticky: a beat arrived with nothing outstanding
//   app_en/app_cmd/app_addr/app_rdy          MIG command channel
//   app_rd_data/_valid/_end                  MIG read-data channel
//   rd_data/rd_valid   registered copy of the read-data channel
//   rd_count           beats received in the current run
// ---------------------------------------------------------------------------
module ddr2_read_engine #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 128,
  parameter int ADDR_STEP       = 8,
  parameter int LEN_W           = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int OUT_W           = 5
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  input  logic              app_rd_data_end,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [LEN_W-1:0]  rd_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(ADDR_STEP);
  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  state_t              state_q, state_d;
  logic                app_en_q, app_en_d;
  logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic [LEN_W-1:0]    rd_count_q, rd_count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  logic                accept;
  logic                ret_ok;
  logic                ret_bad;

  // End-of-burst carries no information with one beat per command.
  logic unused_rd_end;
  assign unused_rd_end = app_rd_data_end;

  assign accept  = app_en_q & app_rdy;
  assign ret_ok  = app_rd_data_valid & (out_q != '0);
  assign ret_bad = app_rd_data_valid & (out_q == '0);

  always_comb begin
    state_d    = state_q;
    app_addr_d = app_addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    out_d      = out_q;
    rd_count_d = rd_count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    // Command issue and beat return bookkeeping, independent of state.
    if (accept) begin
      app_addr_d = app_addr_q + ADDR_INC;
      issued_d   = issued_q + LEN_W'(1);
    end
    case ({accept, ret_ok})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
    if (ret_ok) begin
      rd_count_d = rd_count_q + LEN_W'(1);
    end
    if (ret_bad) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          app_addr_d = start_addr;
          len_d      = burst_len;
          issued_d   = '0;
          rd_count_d = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = (burst_len == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issued_d == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((rd_count_q == len_q) && (out_q == '0)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // app_en is registered from next-state counters so it drops in the cycle
    // after the accept that fills the window or issues the last command, and
    // can only change while app_rdy is low when a returned beat frees a slot.
    app_en_d = (state_d == S_ISSUE) && (out_d < OUT_MAX) && (issued_d < len_d);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      app_en_q   <= 1'b0;
      app_addr_q <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      out_q      <= '0;
      rd_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      app_en_q   <= app_en_d;
      app_addr_q <= app_addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      out_q      <= out_d;
      rd_count_q <= rd_count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_data_q  <= app_rd_data;
      rd_valid_q <= app_rd_data_valid;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign app_en   = app_en_q;
  assign app_cmd  = 3'b001;
  assign app_addr = app_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_count = rd_count_q;

endmodule

// File: doc/ddr2_read_engine.md
Name: ddr2_read_engine

Overview:
- Parametrised successor to the single-command DDR2 read sequencer. Issues a programmable-length run of read commands on the MIG user (app_*) interface from a given start address, with a fixed address stride.
- Limits reads in flight to a credit window, counts returned beats, and forwards read data on a registered stream port.
- Sits between the test/control logic and the MIG user interface, alongside the write controller.

Parameters:
- ADDR_W, 27, app_addr width.
- DATA_W, 128, app_rd_data width.
- ADDR_STEP, 8, address increment per accepted command.
- LEN_W, 16, width of burst_len and the beat counters.
- MAX_OUTSTANDING, 16, maximum accepted-but-unreturned commands; must be at least 1.
- OUT_W, 5, outstanding counter width; must hold MAX_OUTSTANDING.

Ports:
- clk_in  in  1  single system clock (MIG ui_clk).
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first command address; latched on start.
- burst_len  in  LEN_W  number of read commands; latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when all data has returned.
- err  out  1  sticky; set on an unexpected read-data beat; cleared on start.
- app_en  out  1  MIG command valid.
- app_cmd  out  3  fixed 3'b001 (read).
- app_addr  out  ADDR_W  MIG command address.
- app_rdy  in  1  MIG command accept.
- app_rd_data  in  DATA_W  MIG read data.
- app_rd_data_valid  in  1  MIG read data valid.
- app_rd_data_end  in  1  MIG end of burst; unused except for lint tie-off.
- rd_data  out  DATA_W  registered copy of app_rd_data.
- rd_valid  out  1  registered copy of app_rd_data_valid.
- rd_count  out  LEN_W  beats received in the current run.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - app_en=0, app_cmd=3'b001, app_addr=0.
  - busy=0, done=0, err=0.
  - rd_data=0, rd_valid=0, rd_count=0.
  - Outstanding counter and issue counter = 0.
- Reset asserted mid-run abandons the run immediately. Data arriving after reset release is flagged by err, because the outstanding count is 0.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - On start, latch start_addr into app_addr and burst_len into the length register.
  - Clear rd_count, the issue counter and err; set busy.
  - If burst_len==0, go to FINISH. Otherwise go to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - app_en=1 whenever outstanding < MAX_OUTSTANDING and issued < length.
  - A command is accepted in a cycle where app_en & app_rdy is sampled high.
  - While app_rdy=0, app_en and app_addr hold stable.
  - On accept: app_addr <= app_addr + ADDR_STEP (modulo 2^ADDR_W, wraps silently); issued++; outstanding++.
  - At outstanding==MAX_OUTSTANDING, app_en drops to 0 in the next cycle; no accept may occur at full.
  - When the last command is accepted, app_en drops the next cycle and the state moves to DRAIN.
- DRAIN: wait until rd_count==length and outstanding==0, then go to FINISH.
- FINISH: done=1 for exactly one cycle; busy=0; return to IDLE.
- Read return, active in all states:
  - rd_data <= app_rd_data and rd_valid <= app_rd_data_valid; latency 1 cycle.
  - On app_rd_data_valid with outstanding>0: outstanding--; rd_count++.
  - On app_rd_data_valid with outstanding==0: set err; counters unchanged; data still forwarded.
- Simultaneous accept and return in one cycle: outstanding unchanged, issued++, rd_count++.
- One returned beat is expected per command (BL8 on a 4:1 controller yields one DATA_W beat).

Test Plan:
- start_addr=0x100, burst_len=4, app_rdy=1, data returned 3 cycles after each accept -> app_addr sequence 0x100, 0x108, 0x110, 0x118; 4 rd_valid beats with data matched; rd_count=4; done pulses once; busy low afterwards.
- app_rdy toggled 0/1 pseudo-randomly, burst_len=10 -> app_addr stable while app_en=1 and app_rdy=0; exactly 10 accepts; no duplicated or skipped addresses.
- MAX_OUTSTANDING=2, data withheld for 20 cycles, burst_len=6 -> app_en low after 2 accepts; resumes one command per returned beat; done after the 6th beat.
- start_addr=27'h7FFFFF8, burst_len=2 -> second address 0x0000000 (wrap); run completes normally.
- burst_len=0 -> no app_en assertion; done pulses 2 cycles after start. Then app_rd_data_valid pulsed while IDLE -> err=1 and stays set until the next start.
- rst_n pulsed low during ISSUE with 3 reads outstanding -> all outputs return to reset values asynchronously; the next start runs cleanly.
